// File: rtl/mvm_pkg.sv
// mvm_pkg: constants and types shared between the MVM top level and its
// result drain.
//   MVM_OWIDTH      default width of one lane result
//   MVM_NUM_OLANES  default number of result lanes per set
//   drain_state_t   read-side state of the result drain
package mvm_pkg;

    localparam int MVM_OWIDTH     = 32;
    localparam int MVM_NUM_OLANES = 8;

    typedef enum logic {
        DRAIN_IDLE   = 1'b0,
        DRAIN_STREAM = 1'b1
    } drain_state_t;

endpackage

// File: rtl/drain_set_buf.sv
// drain_set_buf: NUM_SETS-deep buffer of whole result sets, with write and
// read pointers that wrap modulo NUM_SETS.
//   clk, rst  clock, async active-low reset (pointers only)
//   wr_en     store wr_data into slot wr_ptr, advance wr_ptr
//   wr_data   one full result set
//   rd_adv    advance rd_ptr (set popped)
//   cur_set   set at rd_ptr (the one being streamed)
//   nxt_set   set at rd_ptr+1 (the one that follows a pop)
module drain_set_buf
    import mvm_pkg::*;
#(
    parameter int OWIDTH     = MVM_OWIDTH,
    parameter int NUM_OLANES = MVM_NUM_OLANES,
    parameter int NUM_SETS   = 4
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [0:NUM_OLANES-1][OWIDTH-1:0]     wr_data,
    input  logic                                  rd_adv,
    output logic [0:NUM_OLANES-1][OWIDTH-1:0]     cur_set,
    output logic [0:NUM_OLANES-1][OWIDTH-1:0]     nxt_set
);

    localparam int PW = $clog2(NUM_SETS);

    logic [0:NUM_OLANES-1][OWIDTH-1:0] mem [NUM_SETS];
    logic [PW-1:0]                     wr_ptr;
    logic [PW-1:0]                     rd_ptr;

    // Data storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // NUM_SETS is a power of two, so natural overflow gives the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_adv)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign cur_set = mem[rd_ptr];
    assign nxt_set = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/mvm_result_drain.sv
// mvm_result_drain: buffers whole result sets from the MVM engine and streams
// them out one lane per beat under valid/ready handshake.
//   clk, rst     clock, async active-low reset
//   i_result     one result set, lane i in i_result[i]
//   i_valid      single-cycle pulse, i_result valid (no backpressure)
//   i_relu_en    clamp negative results to 0 as beats are loaded
//   o_data       streamed lane result
//   o_lane       lane index of o_data
//   o_valid      beat valid
//   i_ready      downstream accepts the current beat
//   o_last       beat carries the final lane of its set
//   o_count      buffered sets, including the one streaming
//   o_overflow   sticky: a set was dropped because the buffer was full
//   i_clear_ovf  clears o_overflow (a same-cycle drop takes priority)
module mvm_result_drain
    import mvm_pkg::*;
#(
    parameter int OWIDTH     = MVM_OWIDTH,
    parameter int NUM_OLANES = MVM_NUM_OLANES,
    parameter int NUM_SETS   = 4
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [0:NUM_OLANES-1][OWIDTH-1:0]     i_result,
    input  logic                                  i_valid,
    input  logic                                  i_relu_en,
    output logic [OWIDTH-1:0]                     o_data,
    output logic [$clog2(NUM_OLANES)-1:0]         o_lane,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic                                  o_last,
    output logic [$clog2(NUM_SETS):0]             o_count,
    output logic                                  o_overflow,
    input  logic                                  i_clear_ovf
);

    localparam int LW = $clog2(NUM_OLANES);
    localparam int CW = $clog2(NUM_SETS) + 1;

    drain_state_t                      state;
    logic [LW-1:0]                     lane_q;
    logic [LW-1:0]                     lane_nxt;
    logic [0:NUM_OLANES-1][OWIDTH-1:0] cur_set;
    logic [0:NUM_OLANES-1][OWIDTH-1:0] nxt_set;
    logic                              beat;
    logic                              pop;
    logic                              full;
    logic                              wr_acc;
    logic                              drop;

    function automatic logic [OWIDTH-1:0] relu(input logic [OWIDTH-1:0] v,
                                               input logic en);
        return (en && v[OWIDTH-1]) ? '0 : v;
    endfunction

    assign beat     = o_valid & i_ready;
    assign pop      = beat & o_last;
    assign full     = (o_count == CW'(NUM_SETS));
    // A full buffer still takes a write when the head set leaves this cycle.
    assign wr_acc   = i_valid & (~full | pop);
    assign drop     = i_valid & ~wr_acc;
    assign lane_nxt = lane_q + LW'(1);
    assign o_lane   = lane_q;

    drain_set_buf #(
        .OWIDTH     (OWIDTH),
        .NUM_OLANES (NUM_OLANES),
        .NUM_SETS   (NUM_SETS)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_data (i_result),
        .rd_adv  (pop),
        .cur_set (cur_set),
        .nxt_set (nxt_set)
    );

    // Occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_acc && !pop)
                o_count <= o_count + CW'(1);
            else if (pop && !wr_acc)
                o_count <= o_count - CW'(1);

            if (drop)
                o_overflow <= 1'b1;
            else if (i_clear_ovf)
                o_overflow <= 1'b0;
        end
    end

    // Read FSM. Beat outputs are registered and only reloaded on a transfer,
    // which keeps them stable under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DRAIN_IDLE;
            lane_q  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    if (o_count != '0) begin
                        state   <= DRAIN_STREAM;
                        o_valid <= 1'b1;
                        lane_q  <= '0;
                        o_last  <= 1'b0;  // lane 0 is never last (NUM_OLANES >= 2)
                        o_data  <= relu(cur_set[0], i_relu_en);
                    end
                end
                DRAIN_STREAM: begin
                    if (beat) begin
                        if (o_last) begin
                            lane_q <= '0;
                            o_last <= 1'b0;
                            if (o_count > CW'(1)) begin
                                // Next set already sits behind the head.
                                o_data <= relu(nxt_set[0], i_relu_en);
                            end else if (wr_acc) begin
                                // Next set is landing this very edge; take it
                                // straight from the input to avoid a bubble.
                                o_data <= relu(i_result[0], i_relu_en);
                            end else begin
                                state   <= DRAIN_IDLE;
                                o_valid <= 1'b0;
                            end
                        end else begin
                            lane_q <= lane_nxt;
                            o_last <= (lane_nxt == LW'(NUM_OLANES - 1));
                            o_data <= relu(cur_set[lane_nxt], i_relu_en);
                        end
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mvm_result_drain.md
MVM_RESULT_DRAIN -- requirements
Module: mvm_result_drain

Interface
REQ-001 Parameter OWIDTH, default 32, width of each lane result and of o_data.
REQ-002 Parameter NUM_OLANES, default 8, number of result lanes per set.
REQ-003 Parameter NUM_SETS, default 4, result-set buffer depth; a power of two, at least 2.
REQ-004 Ports, one per line:
  clk  input  1  sole clock; all state updates on posedge.
  rst  input  1  asynchronous, active-low reset.
  i_result  input  OWIDTH x [0:NUM_OLANES-1]  one result set from the MVM engine.
  i_valid  input  1  i_result valid this cycle; single-cycle pulse, no backpressure possible.
  i_relu_en  input  1  clamp negative signed results to 0 on output.
  o_data  output  OWIDTH  streamed lane result.
  o_lane  output  $clog2(NUM_OLANES)  lane index of o_data.
  o_valid  output  1  o_data/o_lane/o_last valid.
  i_ready  input  1  downstream accepts the current beat.
  o_last  output  1  beat carries lane NUM_OLANES-1.
  o_count  output  $clog2(NUM_SETS)+1  number of buffered sets, including the one being streamed.
  o_overflow  output  1  sticky flag: a set was dropped.
  i_clear_ovf  input  1  synchronous clear of o_overflow.

Function
REQ-005 The block SHALL capture the full i_result array into buffer slot wr_ptr on every cycle with i_valid=1 when the buffer accepts (REQ-006).
REQ-006 A write SHALL be accepted when o_count<NUM_SETS, or when o_count=NUM_SETS and a set pop (REQ-010) occurs in the same cycle.
REQ-007 A rejected write SHALL leave the buffer, pointers and o_count unchanged and SHALL set o_overflow=1 on the next edge.
REQ-008 i_clear_ovf=1 SHALL clear o_overflow next edge; when it coincides with a drop, the set wins and o_overflow stays 1.
REQ-009 The read FSM SHALL have two states: IDLE (o_valid=0) and STREAM (o_valid=1); IDLE->STREAM when o_count>0; STREAM->IDLE on a pop leaving o_count=0 with no same-cycle write.
REQ-010 A beat SHALL transfer only when o_valid=1 and i_ready=1; lane counter increments per beat; the o_last beat is a pop: rd_ptr advances, lane counter resets to 0.
REQ-011 While o_valid=1 and i_ready=0, o_data, o_lane and o_last SHALL hold stable.
REQ-012 o_data SHALL equal buffer[rd_ptr][lane], replaced by 0 when i_relu_en=1 and its MSB is 1; i_relu_en is sampled per beat.
REQ-013 Latency: a set written at edge N into an empty buffer in IDLE SHALL present lane 0 with o_valid=1 after edge N+1; with i_ready held 1, there SHALL be one beat per cycle, back-to-back across sets with no bubble.
REQ-014 o_count SHALL increment on an accepted write without a pop, decrement on a pop without a write, and be unchanged when both or neither occur.
REQ-015 wr_ptr and rd_ptr SHALL wrap modulo NUM_SETS.
REQ-016 i_valid arriving mid-set SHALL NOT disturb the set currently streaming.

Reset
REQ-017 rst=0 SHALL asynchronously force: FSM=IDLE, pointers=0, lane counter=0, o_count=0, o_valid=0, o_last=0, o_lane=0, o_data=0, o_overflow=0.
REQ-018 Reset mid-stream SHALL discard all buffered sets; buffer contents need not be cleared.
REQ-019 After reset release, the first i_valid SHALL be accepted on the first clock edge.

Structure
REQ-020 Shared package mvm_pkg SHALL hold the drain FSM state enum and the default OWIDTH and NUM_OLANES constants, shared with the MVM top level.
REQ-021 One sub-module, drain_set_buf, SHALL contain the NUM_SETS x NUM_OLANES x OWIDTH register buffer with its write and read pointers; the FSM and lane counter stay in mvm_result_drain.

Verification
REQ-022 Single set: write lanes 0..7 = 10..17, i_ready=1 -> 8 consecutive beats with o_data 10..17, o_lane 0..7, o_last only on 17; o_count 1->0.
REQ-023 Backpressure: i_ready toggles 1,0,0,1,... -> each beat is held stable while i_ready=0; no beat is duplicated or lost.
REQ-024 Overflow: i_ready=0, five i_valid pulses with NUM_SETS=4 -> o_count=4, o_overflow=1, the fifth set is never streamed; i_clear_ovf -> o_overflow=0.
REQ-025 Full with simultaneous pop: o_count=4, a write coincides with the o_last beat -> write accepted, o_count stays 4, o_overflow stays 0.
REQ-026 ReLU: lane value 32'hFFFF_FFF6 (-10) with i_relu_en=1 -> o_data=0; with i_relu_en=0 -> 32'hFFFF_FFF6.
REQ-027 Reset mid-stream: rst=0 after beat 3 of set 1 with two sets buffered -> o_valid=0 immediately; after release, a new set streams from lane 0.
